// File: rtl/traffic_light_xing.sv
// Two-road intersection controller: NS/EW green-yellow-all-red sequencing on an external tick,
// with pedestrian request shortening of NS green, a walk lamp and a night flashing mode.
module traffic_light_xing #(
    parameter int CNT_W      = 8,
    parameter int NS_G_TIME  = 30,
    parameter int EW_G_TIME  = 20,
    parameter int Y_TIME     = 3,
    parameter int AR_TIME    = 2,
    parameter int SHORT_TIME = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             pass_request,
    input  logic             flash_mode,
    output logic [CNT_W-1:0] clock,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green,
    output logic             ped_walk,
    output logic             ped_pending
);

    localparam int MAX_T = (1 << CNT_W) - 1;

    if (NS_G_TIME < 1 || EW_G_TIME < 1 || Y_TIME < 1 || AR_TIME < 1 || SHORT_TIME < 1 ||
        SHORT_TIME >= NS_G_TIME || NS_G_TIME > MAX_T || EW_G_TIME > MAX_T ||
        Y_TIME > MAX_T || AR_TIME > MAX_T) begin : g_bad_params
        $error("traffic_light_xing: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] T_NS    = CNT_W'(NS_G_TIME);
    localparam logic [CNT_W-1:0] T_EW    = CNT_W'(EW_G_TIME);
    localparam logic [CNT_W-1:0] T_Y     = CNT_W'(Y_TIME);
    localparam logic [CNT_W-1:0] T_AR    = CNT_W'(AR_TIME);
    localparam logic [CNT_W-1:0] T_SHORT = CNT_W'(SHORT_TIME);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        NS_GREEN, NS_YELLOW, AR1, EW_GREEN, EW_YELLOW, AR2, FLASH
    } state_t;

    state_t state;
    logic   expire;
    logic   shorten;

    function automatic state_t next_phase(input state_t s);
        case (s)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return AR1;
            AR1:       return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return AR2;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] phase_time(input state_t s, input logic short_ns);
        case (s)
            NS_GREEN:             return short_ns ? T_SHORT : T_NS;
            NS_YELLOW, EW_YELLOW: return T_Y;
            EW_GREEN:             return T_EW;
            AR1, AR2:             return T_AR;
            default:              return '0;
        endcase
    endfunction

    // Bit order {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}.
    function automatic logic [5:0] lamp_set(input state_t s);
        case (s)
            NS_GREEN:  return 6'b001_100;
            NS_YELLOW: return 6'b010_100;
            EW_GREEN:  return 6'b100_001;
            EW_YELLOW: return 6'b100_010;
            AR1, AR2:  return 6'b100_100;
            default:   return 6'b000_000;
        endcase
    endfunction

    assign expire  = tick && (clock == ONE);
    assign shorten = (state == NS_GREEN) && pass_request && (clock > T_SHORT);

    // NOTE: every register uses <= so all outputs are computed from the same pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= NS_GREEN;
            clock       <= T_NS;
            {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} <= lamp_set(NS_GREEN);
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
        end else if (flash_mode) begin
            state       <= FLASH;
            clock       <= '0;
            {ns_red, ns_green, ew_red, ew_green} <= 4'b0000;
            ns_yellow   <= (state != FLASH) | (ns_yellow ^ tick);
            ew_yellow   <= (state != FLASH) | (ns_yellow ^ tick);
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
        end else if (state == FLASH) begin
            if (tick) begin
                state    <= AR2;
                clock    <= T_AR;
                {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} <= lamp_set(AR2);
                ped_walk <= 1'b0;
            end
        end else begin
            // A request shortening NS green wins over a coincident tick; it never coincides with expiry.
            if (shorten) begin
                clock <= T_SHORT;
            end else if (expire) begin
                state    <= next_phase(state);
                clock    <= phase_time(next_phase(state), ped_pending | pass_request);
                {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} <= lamp_set(next_phase(state));
                ped_walk <= (next_phase(state) == EW_GREEN);
            end else if (tick) begin
                clock <= clock - ONE;
            end

            if (expire && state == AR1) begin
                ped_pending <= 1'b0;
            end else if (pass_request) begin
                ped_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_xing.sv
// Self-checking bench for traffic_light_xing: vector table, directed corner sequences and
// randomized stimulus compared against a phase-table reference model.
module tb_traffic_light_xing;

    localparam int CNT_W      = 8;
    localparam int NS_G_TIME  = 30;
    localparam int EW_G_TIME  = 20;
    localparam int Y_TIME     = 3;
    localparam int AR_TIME    = 2;
    localparam int SHORT_TIME = 5;

    localparam logic [5:0] L_NSG  = 6'b001_100;
    localparam logic [5:0] L_NSY  = 6'b010_100;
    localparam logic [5:0] L_AR   = 6'b100_100;
    localparam logic [5:0] L_EWG  = 6'b100_001;
    localparam logic [5:0] L_EWY  = 6'b100_010;
    localparam logic [5:0] L_FYEL = 6'b010_010;
    localparam logic [5:0] L_OFF  = 6'b000_000;

    logic             clk = 1'b1;
    logic             rst;
    logic             tick;
    logic             pass_request;
    logic             flash_mode;
    logic [CNT_W-1:0] clock;
    logic             ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic             ped_walk, ped_pending;

    int errors = 0;
    int checks = 0;

    traffic_light_xing #(
        .CNT_W(CNT_W), .NS_G_TIME(NS_G_TIME), .EW_G_TIME(EW_G_TIME),
        .Y_TIME(Y_TIME), .AR_TIME(AR_TIME), .SHORT_TIME(SHORT_TIME)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .pass_request(pass_request), .flash_mode(flash_mode),
        .clock(clock), .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .ped_walk(ped_walk), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: phase index 0..5 in road order, plus a flashing flag.
    int   dur[6]      = '{NS_G_TIME, Y_TIME, AR_TIME, EW_G_TIME, Y_TIME, AR_TIME};
    logic [5:0] lamp_tab[6] = '{L_NSG, L_NSY, L_AR, L_EWG, L_EWY, L_AR};
    int   m_phase;
    int   m_rem;
    bit   m_flash;
    bit   m_pend;
    bit   m_yel;

    task automatic model_reset();
        m_phase = 0; m_rem = NS_G_TIME; m_flash = 0; m_pend = 0; m_yel = 0;
    endtask

    task automatic model_step(input bit tk, input bit rq, input bit fm);
        bit old_pend;
        bit enter_ew;
        if (fm) begin
            m_yel   = m_flash ? (tk ? !m_yel : m_yel) : 1'b1;
            m_flash = 1;
            m_rem   = 0;
            m_pend  = 0;
        end else if (m_flash) begin
            if (tk) begin
                m_flash = 0; m_phase = 5; m_rem = AR_TIME; m_yel = 0;
            end
        end else begin
            old_pend = m_pend;
            enter_ew = tk && m_rem == 1 && m_phase == 2;
            if (m_phase == 0 && rq && m_rem > SHORT_TIME) begin
                m_rem = SHORT_TIME;
            end else if (tk) begin
                if (m_rem == 1) begin
                    m_phase = (m_phase + 1) % 6;
                    m_rem   = (m_phase == 0 && (old_pend || rq)) ? SHORT_TIME : dur[m_phase];
                end else begin
                    m_rem = m_rem - 1;
                end
            end
            m_pend = enter_ew ? 1'b0 : (old_pend | rq);
        end
    endtask

    function automatic logic [15:0] model_out();
        if (m_flash) return {8'd0, 1'b0, m_yel, 2'b00, m_yel, 1'b0, 2'b00};
        return {m_rem[7:0], lamp_tab[m_phase], (m_phase == 3), m_pend};
    endfunction

    function automatic logic [15:0] dut_out();
        return {clock, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk, ped_pending};
    endfunction

    function automatic logic [5:0] lamps();
        return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit tk, input bit rq, input bit fm);
        tick = tk; pass_request = rq; flash_mode = fm;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit tk, input bit rq, input bit fm);
        apply(tk, rq, fm);
        model_step(tk, rq, fm);
        check("model", dut_out(), model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tick = 0; pass_request = 0; flash_mode = 0;
        #1;
        model_reset();
        check("reset", dut_out(), {8'd30, L_NSG, 2'b00});
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         tk;
        bit         rq;
        bit         fm;
        logic [7:0] clk_v;
        logic [5:0] lmp;
        bit         walk;
        bit         pend;
    } vec_t;

    vec_t vecs[16];
    bit   fm_r;

    initial begin
        vecs[0]  = '{0, 0, 0, 8'd30, L_NSG,  0, 0};
        vecs[1]  = '{1, 0, 0, 8'd29, L_NSG,  0, 0};
        vecs[2]  = '{1, 1, 0, 8'd5,  L_NSG,  0, 1};
        vecs[3]  = '{1, 0, 0, 8'd4,  L_NSG,  0, 1};
        vecs[4]  = '{0, 1, 0, 8'd4,  L_NSG,  0, 1};
        vecs[5]  = '{1, 0, 0, 8'd3,  L_NSG,  0, 1};
        vecs[6]  = '{0, 0, 1, 8'd0,  L_FYEL, 0, 0};
        vecs[7]  = '{1, 0, 1, 8'd0,  L_OFF,  0, 0};
        vecs[8]  = '{0, 0, 1, 8'd0,  L_OFF,  0, 0};
        vecs[9]  = '{1, 0, 1, 8'd0,  L_FYEL, 0, 0};
        vecs[10] = '{0, 1, 0, 8'd0,  L_FYEL, 0, 0};
        vecs[11] = '{1, 0, 0, 8'd2,  L_AR,   0, 0};
        vecs[12] = '{1, 0, 0, 8'd1,  L_AR,   0, 0};
        vecs[13] = '{1, 0, 0, 8'd30, L_NSG,  0, 0};
        vecs[14] = '{1, 1, 0, 8'd5,  L_NSG,  0, 1};
        vecs[15] = '{1, 0, 0, 8'd4,  L_NSG,  0, 1};

        rst = 1'b1; tick = 0; pass_request = 0; flash_mode = 0;
        #14;
        check("reset_initial", dut_out(), {8'd30, L_NSG, 2'b00});
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].tk, vecs[i].rq, vecs[i].fm);
            check($sformatf("vec%0d", i), dut_out(),
                  {vecs[i].clk_v, vecs[i].lmp, vecs[i].walk, vecs[i].pend});
        end

        // Full cycle with a tick every clock.
        do_reset();
        for (int p = 0; p < 6; p++) begin
            for (int c = dur[p]; c >= 1; c--) begin
                check("loop_clock", clock, c);
                check("loop_lamps", lamps(), lamp_tab[p]);
                check("loop_walk", ped_walk, (p == 3));
                check("loop_both_not_red", ns_red | ew_red, 1);
                drive(1, 0, 0);
            end
        end
        check("loop_back_ns_green", {clock, lamps()}, {8'd30, L_NSG});

        // Request at clock=18 shortens NS green; pending clears on EW green entry.
        do_reset();
        repeat (12) drive(1, 0, 0);
        check("req18_pre", clock, 18);
        drive(1, 1, 0);
        check("req18_short", {clock, ped_pending}, {8'd5, 1'b1});
        repeat (4) drive(1, 0, 0);
        check("req18_last_green", {clock, lamps()}, {8'd1, L_NSG});
        drive(1, 0, 0);
        check("req18_yellow", {clock, lamps()}, {8'd3, L_NSY});
        repeat (4) drive(1, 0, 0);
        check("req18_pend_held", ped_pending, 1);
        drive(1, 0, 0);
        check("req18_ew_entry", {clock, lamps(), ped_walk, ped_pending}, {8'd20, L_EWG, 2'b10});

        // Request during EW yellow only latches; next NS green is short.
        repeat (20) drive(1, 0, 0);
        check("ewy_entry", {clock, lamps()}, {8'd3, L_EWY});
        drive(1, 1, 0);
        check("ewy_req", {clock, lamps(), ped_pending}, {8'd2, L_EWY, 1'b1});
        repeat (4) drive(1, 0, 0);
        check("ns_short_entry", {clock, lamps(), ped_pending}, {8'd5, L_NSG, 1'b1});

        // Request at clock=4 does not alter timing.
        do_reset();
        repeat (26) drive(1, 0, 0);
        check("req4_pre", clock, 4);
        drive(1, 1, 0);
        check("req4_a", {clock, ped_pending}, {8'd3, 1'b1});
        drive(1, 0, 0);
        check("req4_b", clock, 2);
        drive(1, 0, 0);
        check("req4_c", clock, 1);

        // Flash entered mid EW green, then released.
        do_reset();
        repeat (38) drive(1, 0, 0);
        check("fl_pre", {clock, lamps()}, {8'd17, L_EWG});
        drive(0, 0, 1);
        check("fl_entry", {clock, lamps(), ped_walk}, {8'd0, L_FYEL, 1'b0});
        drive(1, 0, 1);
        check("fl_toggle0", lamps(), L_OFF);
        drive(1, 0, 1);
        check("fl_toggle1", lamps(), L_FYEL);
        drive(0, 0, 0);
        check("fl_wait_tick", lamps(), L_FYEL);
        drive(1, 0, 0);
        check("fl_exit_ar2", {clock, lamps()}, {8'd2, L_AR});
        repeat (2) drive(1, 0, 0);
        check("fl_ns_green", {clock, lamps()}, {8'd30, L_NSG});

        // Asynchronous reset mid NS yellow with tick idle.
        do_reset();
        repeat (31) drive(1, 0, 0);
        check("ar_pre", {clock, lamps()}, {8'd2, L_NSY});
        tick = 0;
        #1 rst = 1'b1;
        #1 check("async_reset", dut_out(), {8'd30, L_NSG, 2'b00});
        model_reset();
        @(posedge clk);
        #1 check("async_reset_hold", dut_out(), {8'd30, L_NSG, 2'b00});
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the model.
        do_reset();
        fm_r = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) fm_r = !fm_r;
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, fm_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
